image_ram: RTL and testbench



---
 rtl/image_ram_pkg.sv | 36 +++
 rtl/image_ram_rd_port.sv | 63 ++++++
 rtl/image_ram.sv | 115 +++++++++++
 tb/tb_image_ram.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ram_pkg.sv
// image_ram_pkg: shared constants and the pixel word layout for the image
// pixel memory. The original frame occupies words 0..IMG_PIXELS-1 and the
// temporary processed frame starts at TMP_OFFSET.
package image_ram_pkg;

    // Default geometry of the pixel memory
    localparam int DEF_DEPTH  = 262144;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Frame layout
    localparam int IMG_W      = 320;
    localparam int IMG_PIXELS = 102400;
    localparam int TMP_OFFSET = 131072;

    // One pixel per 32-bit word: 0x00RRGGBB
    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Build a pixel word with a zero pad byte
    function automatic pixel_t make_pixel(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        pixel_t p;
        p.pad = 8'h00;
        p.r   = r;
        p.g   = g;
        p.b   = b;
        return p;
    endfunction

endpackage

// File: rtl/image_ram_rd_port.sv
// image_ram_rd_port: one registered read port of the pixel memory.
// Holds the address range check, the optional write-forwarding mux and the
// output register. Forwarding is compiled in when IMAGE_RAM_WR_FWD_EN is
// defined; otherwise a same-cycle write is not visible (read-first).
module image_ram_rd_port
    import image_ram_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_mem_data,
`ifdef IMAGE_RAM_WR_FWD_EN
    input  logic              i_wr0,
    input  logic [ADDR_W-1:0] i_addr_wr0,
    input  logic [DATA_W-1:0] i_data_wr0,
    input  logic              i_wr1,
    input  logic [ADDR_W-1:0] i_addr_wr1,
    input  logic [DATA_W-1:0] i_data_wr1,
`endif
    output logic [DATA_W-1:0] o_data
);

    // Extra top bit so DEPTH itself is representable for any ADDR_W
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic              w_in_range;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_data;

    assign w_in_range = ({1'b0, i_addr} < LP_DEPTH);

    // Select the word to load: zero when out of range, else array (or forwarded write)
    always_comb begin
        w_next = i_mem_data;
        if (!w_in_range) begin
            w_next = '0;
        end
`ifdef IMAGE_RAM_WR_FWD_EN
        else if (i_wr1 && (i_addr_wr1 == i_addr)) begin
            w_next = i_data_wr1;
        end else if (i_wr0 && (i_addr_wr0 == i_addr)) begin
            w_next = i_data_wr0;
        end
`endif
    end

    // Output register: cleared by reset, loaded on a read strobe, otherwise held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_read) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/image_ram.sv
// image_ram: two-write / two-read pixel memory for the image processor.
// Port 0 serves the original-frame reader and temporary-frame writer; port 1
// serves the temporary-frame reader and original-frame writer.
// Optional feature macro: IMAGE_RAM_WR_FWD_EN (same-cycle write forwarding).
//
// Strobe semantics: WRITEn / READn are single-cycle qualifiers sampled at a
// rising edge together with their address/data; there is no back-pressure.
// A read strobed at edge N presents data after edge N, held until the next
// read strobe on that port or reset. A write at edge N is visible to a read
// strobed at edge N+1.
module image_ram
    import image_ram_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WRITE0,
    input  logic              WRITE1,
    input  logic              READ0,
    input  logic              READ1,
    input  logic [ADDR_W-1:0] addr_wr0,
    input  logic [ADDR_W-1:0] addr_wr1,
    input  logic [ADDR_W-1:0] addr_rd0,
    input  logic [ADDR_W-1:0] addr_rd1,
    input  logic [DATA_W-1:0] datain0,
    input  logic [DATA_W-1:0] datain1,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    // Pixel array; deliberately not cleared by reset
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic [IDX_W-1:0]  w_wr0_idx;
    logic [IDX_W-1:0]  w_wr1_idx;
    logic [IDX_W-1:0]  w_rd0_idx;
    logic [IDX_W-1:0]  w_rd1_idx;
    logic [DATA_W-1:0] w_rd0_word;
    logic [DATA_W-1:0] w_rd1_word;

    // Writes only land when the full address is inside the array
    assign w_wr0_ok  = WRITE0 && ({1'b0, addr_wr0} < LP_DEPTH);
    assign w_wr1_ok  = WRITE1 && ({1'b0, addr_wr1} < LP_DEPTH);
    assign w_wr0_idx = addr_wr0[IDX_W-1:0];
    assign w_wr1_idx = addr_wr1[IDX_W-1:0];

    // Truncated read indices; the read port discards the word when out of range
    assign w_rd0_idx  = addr_rd0[IDX_W-1:0];
    assign w_rd1_idx  = addr_rd1[IDX_W-1:0];
    assign w_rd0_word = r_mem[w_rd0_idx];
    assign w_rd1_word = r_mem[w_rd1_idx];

    // Array write: blocked while reset is high; port 1 is applied last so it wins a collision
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            if (w_wr0_ok) begin
                r_mem[w_wr0_idx] <= datain0;
            end
            if (w_wr1_ok) begin
                r_mem[w_wr1_idx] <= datain1;
            end
        end
    end

    image_ram_rd_port #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd0 (
        .clk        (clk),
        .rst        (rst),
        .i_read     (READ0),
        .i_addr     (addr_rd0),
        .i_mem_data (w_rd0_word),
`ifdef IMAGE_RAM_WR_FWD_EN
        .i_wr0      (WRITE0),
        .i_addr_wr0 (addr_wr0),
        .i_data_wr0 (datain0),
        .i_wr1      (WRITE1),
        .i_addr_wr1 (addr_wr1),
        .i_data_wr1 (datain1),
`endif
        .o_data     (dataout0)
    );

    image_ram_rd_port #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd1 (
        .clk        (clk),
        .rst        (rst),
        .i_read     (READ1),
        .i_addr     (addr_rd1),
        .i_mem_data (w_rd1_word),
`ifdef IMAGE_RAM_WR_FWD_EN
        .i_wr0      (WRITE0),
        .i_addr_wr0 (addr_wr0),
        .i_data_wr0 (datain0),
        .i_wr1      (WRITE1),
        .i_addr_wr1 (addr_wr1),
        .i_data_wr1 (datain1),
`endif
        .o_data     (dataout1)
    );

endmodule

// File: tb/tb_image_ram.sv
// tb_image_ram: bench for image_ram with a behavioural memory model,
// per-cycle output comparison, directed literal checks and random traffic.
// Honours IMAGE_RAM_WR_FWD_EN the same way the design does.
module tb_image_ram;
    import image_ram_pkg::*;

    localparam int unsigned DEPTH = 262144;

    logic        clk;
    logic        rst;
    logic        WRITE0, WRITE1, READ0, READ1;
    logic [31:0] addr_wr0, addr_wr1, addr_rd0, addr_rd1;
    logic [31:0] datain0, datain1;
    logic [31:0] dataout0, dataout1;

    image_ram dut (
        .clk      (clk),
        .rst      (rst),
        .WRITE0   (WRITE0),
        .WRITE1   (WRITE1),
        .READ0    (READ0),
        .READ1    (READ1),
        .addr_wr0 (addr_wr0),
        .addr_wr1 (addr_wr1),
        .addr_rd0 (addr_rd0),
        .addr_rd1 (addr_rd1),
        .datain0  (datain0),
        .datain1  (datain1),
        .dataout0 (dataout0),
        .dataout1 (dataout1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp0, exp1;
    bit          exp0_known, exp1_known;
    bit          run_cmp;
    int          n_tests;
    int          n_fail;

    // Model read of one address given this cycle's writes (before the writes land)
    function automatic void model_read(input int unsigned a,
                                       output logic [31:0] v, output bit k);
        v = 32'h0;
        k = 1'b1;
        if (a >= DEPTH) begin
            v = 32'h0;
        end
`ifdef IMAGE_RAM_WR_FWD_EN
        else if (WRITE1 && addr_wr1 == a) begin
            v = datain1;
        end else if (WRITE0 && addr_wr0 == a) begin
            v = datain0;
        end
`endif
        else if (model_mem.exists(a)) begin
            v = model_mem[a];
        end else begin
            k = 1'b0;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit w0, input int unsigned a0, input logic [31:0] d0,
                        input bit w1, input int unsigned a1, input logic [31:0] d1,
                        input bit r0, input int unsigned ra0,
                        input bit r1, input int unsigned ra1);
        logic [31:0] v;
        bit          k;
        WRITE0 = w0;  addr_wr0 = a0;  datain0 = d0;
        WRITE1 = w1;  addr_wr1 = a1;  datain1 = d1;
        READ0  = r0;  addr_rd0 = ra0;
        READ1  = r1;  addr_rd1 = ra1;
        @(posedge clk);
        if (rst) begin
            exp0 = 32'h0; exp0_known = 1'b1;
            exp1 = 32'h0; exp1_known = 1'b1;
        end else begin
            if (r0) begin
                model_read(ra0, v, k);
                exp0 = v; exp0_known = k;
            end
            if (r1) begin
                model_read(ra1, v, k);
                exp1 = v; exp1_known = k;
            end
            if (w0 && a0 < DEPTH) model_mem[a0] = d0;
            if (w1 && a1 < DEPTH) model_mem[a1] = d1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr0(input int unsigned a, input logic [31:0] d);
        step(1, a, d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd0(input int unsigned a);
        step(0, 0, 0, 0, 0, 0, 1, a, 0, 0);
    endtask

    task automatic rd1(input int unsigned a);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    endtask

    // Literal check against a hand-computed value
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run_cmp) begin
            if (exp0_known) begin
                n_tests++;
                if (dataout0 !== exp0) begin
                    n_fail++;
                    $display("FAIL dataout0 @%0t: got 0x%08h, expected 0x%08h", $time, dataout0, exp0);
                end
            end
            if (exp1_known) begin
                n_tests++;
                if (dataout1 !== exp1) begin
                    n_fail++;
                    $display("FAIL dataout1 @%0t: got 0x%08h, expected 0x%08h", $time, dataout1, exp1);
                end
            end
        end
    end

    // Address pool that concentrates on frame edges, collisions and out-of-range
    function automatic int unsigned pick_addr();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, 15);
            1:       return 102392 + $urandom_range(0, 15);
            2:       return TMP_OFFSET + $urandom_range(0, 15);
            3:       return 262140 + $urandom_range(0, 7);
            default: return 300000;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        pixel_t px;
        n_tests = 0;
        n_fail  = 0;
        run_cmp = 1'b0;
        exp0 = 32'h0; exp1 = 32'h0;
        exp0_known = 1'b1; exp1_known = 1'b1;
        WRITE0 = 0; WRITE1 = 0; READ0 = 0; READ1 = 0;
        addr_wr0 = 0; addr_wr1 = 0; addr_rd0 = 0; addr_rd1 = 0;
        datain0 = 0; datain1 = 0;
        rst = 1'b1;
        #1;
        check("reset_dout0", dataout0, 32'h0);
        check("reset_dout1", dataout1, 32'h0);
        run_cmp = 1'b1;
        @(negedge clk);
        step(1, 5, 32'h99, 0, 0, 0, 1, 5, 0, 0);  // ignored under reset
        check("reset_hold_dout0", dataout0, 32'h0);
        rst = 1'b0;
        idle();

        // Port 0 write then read, held afterwards
        px = make_pixel(8'h11, 8'h22, 8'h33);
        wr0(5, px);
        rd0(5);
        check("wr_rd_p0", dataout0, 32'h00112233);
        idle();
        idle();
        check("wr_rd_p0_hold", dataout0, 32'h00112233);

        // Cross-port accesses at frame edges
        step(0, 0, 0, 1, 102399, 32'h00FFFFFF, 0, 0, 0, 0);
        rd0(102399);
        check("cross_p1_to_p0", dataout0, 32'h00FFFFFF);
        wr0(TMP_OFFSET + 7, 32'h00ABCDEF);
        rd1(131079);
        check("cross_p0_to_p1", dataout1, 32'h00ABCDEF);

        // Upper pad byte is stored too
        wr0(3, 32'hA5000001);
        rd1(3);
        check("pad_byte_kept", dataout1, 32'hA5000001);

        // Both writes on one address: port 1 wins
        step(1, 10, 32'hA, 1, 10, 32'hB, 0, 0, 0, 0);
        rd0(10);
        check("collision_p1_wins", dataout0, 32'hB);

        // Read during write
        wr0(20, 32'h1);
        step(1, 20, 32'h2, 0, 0, 0, 0, 0, 1, 20);
`ifdef IMAGE_RAM_WR_FWD_EN
        check("rdw_forward", dataout1, 32'h2);
`else
        check("rdw_read_first", dataout1, 32'h1);
`endif
        rd1(20);
        check("rdw_after", dataout1, 32'h2);

        // Out of range write and read
        wr0(0, 32'h55);
        wr0(262144, 32'h99);
        rd0(0);
        check("oor_write_no_alias", dataout0, 32'h55);
        rd1(300000);
        check("oor_read_zero", dataout1, 32'h0);

        // Reset mid-stream: output cleared at once, contents kept, writes ignored
        rd0(5);
        check("pre_reset_read", dataout0, 32'h00112233);
        #2;
        rst = 1'b1;
        exp0 = 32'h0; exp0_known = 1'b1;
        exp1 = 32'h0; exp1_known = 1'b1;
        #1;
        check("async_reset_dout0", dataout0, 32'h0);
        check("async_reset_dout1", dataout1, 32'h0);
        @(negedge clk);
        step(1, 5, 32'hDEADBEEF, 1, 0, 32'h77, 1, 5, 1, 0);
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0, 0);
        check("reset_held_dout0", dataout0, 32'h0);
        rst = 1'b0;
        rd0(5);
        check("retained_after_reset", dataout0, 32'h00112233);
        rd1(0);
        check("write_ignored_in_reset", dataout1, 32'h55);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), pick_addr(), $urandom(),
                 $urandom_range(0, 1), pick_addr(), $urandom(),
                 $urandom_range(0, 1), pick_addr(),
                 $urandom_range(0, 1), pick_addr());
        end

        idle();
        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
